// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU control sequencer: op_sel encodings,
// FSM state type, ALU opcode constants and multiply loop layout.
// Optional feature macro: ALU_SEQ_MUL_EN (enables the multiply sequence).
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_TWOS = 2'b01,
        OP_SHR2 = 2'b10,
        OP_MUL  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [11:0] OPC_LOAD_XB     = 12'b000000001011;
    localparam logic [11:0] OPC_LOAD_YC     = 12'b000000001100;
    localparam logic [11:0] OPC_ADD_BC_AO   = 12'b001000000000;
    localparam logic [11:0] OPC_TWOS_B_AO   = 12'b001000001000;
    localparam logic [11:0] OPC_SHR_B_AO    = 12'b001000000100;
    localparam logic [11:0] OPC_AO_TO_B     = 12'b100000001011;
    localparam logic [11:0] OPC_AND_B_LSBC  = 12'b001000000101;
    localparam logic [11:0] OPC_SHL_B       = 12'b001000010011;
    localparam logic [11:0] OPC_SHR_C       = 12'b000000101010;
    localparam logic [11:0] OPC_BO_TO_B     = 12'b100001001011;
    localparam logic [11:0] OPC_TWOS_B_BO   = 12'b001000011000;
    localparam logic [11:0] OPC_AO_TO_A     = 12'b100000001001;
    localparam logic [11:0] OPC_AND_B_LSBCO = 12'b001110000101;
    localparam logic [11:0] OPC_AO_TO_C     = 12'b010000101100;
    localparam logic [11:0] OPC_ADD_AC      = 12'b000000000000;
    localparam logic [11:0] OPC_CO_TO_C     = 12'b010010001100;

    // Multiply layout: steps 0..2 are the prologue, each loop iteration
    // restarts at MUL_BODY_START; SHR_C is always the second body step.
    localparam logic [5:0] MUL_BODY_START = 6'd3;
    localparam logic [5:0] MUL_SHR_C_POS  = 6'd4;
    localparam logic [5:0] MUL_WRAP_POS   = 6'd10;

`ifdef ALU_SEQ_MUL_EN
    localparam logic MUL_ENABLED = 1'b1;
`else
    localparam logic MUL_ENABLED = 1'b0;
`endif

    function automatic logic op_supported(op_e op);
        return !((op == OP_MUL) && !MUL_ENABLED);
    endfunction

endpackage

// File: rtl/alu_seq_rom.sv
// Step-to-opcode lookup for the ALU sequencer.
// Optional feature macro: ALU_SEQ_MUL_EN (multiply table compiled in).
module alu_seq_rom
    import alu_seq_pkg::*;
#(
    parameter int unsigned MUL_ITER = 5
) (
    input  op_e         op,
    input  logic [5:0]  step,
    input  logic [2:0]  iteration,
    input  logic        corr,
    output logic [11:0] opcode,
    output logic        last
);

`ifdef ALU_SEQ_MUL_EN
    localparam logic [2:0] LAST_ITER = 3'(MUL_ITER - 1);
    logic [5:0] body;
    logic [5:0] slot;
`else
    logic unused_mul_inputs;
    assign unused_mul_inputs = ^{iteration, corr, 3'(MUL_ITER)};
`endif

    // Combinational opcode table; last marks the final step of a sequence
    always_comb begin
        opcode = '0;
        last   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        body   = '0;
        slot   = '0;
`endif
        case (op)
            OP_ADD: begin
                case (step)
                    6'd0: opcode = OPC_LOAD_XB;
                    6'd1: opcode = OPC_LOAD_YC;
                    6'd2: begin opcode = OPC_ADD_BC_AO; last = 1'b1; end
                    default: ;
                endcase
            end
            OP_TWOS: begin
                case (step)
                    6'd0: opcode = OPC_LOAD_XB;
                    6'd1: begin opcode = OPC_TWOS_B_AO; last = 1'b1; end
                    default: ;
                endcase
            end
            OP_SHR2: begin
                case (step)
                    6'd0: opcode = OPC_LOAD_XB;
                    6'd1: opcode = OPC_SHR_B_AO;
                    6'd2: opcode = OPC_AO_TO_B;
                    6'd3: begin opcode = OPC_SHR_B_AO; last = 1'b1; end
                    default: ;
                endcase
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
                if (step < MUL_BODY_START) begin
                    case (step)
                        6'd0:    opcode = OPC_LOAD_XB;
                        6'd1:    opcode = OPC_LOAD_YC;
                        default: opcode = OPC_AND_B_LSBC;
                    endcase
                end else begin
                    // Slots 2..3 hold the sign correction; without it the body
                    // index skips over them so step numbering stays contiguous.
                    body = step - MUL_BODY_START;
                    slot = (corr || (body < 6'd2)) ? body : body + 6'd2;
                    case (slot)
                        6'd0: opcode = OPC_SHL_B;
                        6'd1: opcode = OPC_SHR_C;
                        6'd2: opcode = OPC_BO_TO_B;
                        6'd3: opcode = OPC_TWOS_B_BO;
                        6'd4: opcode = OPC_AO_TO_A;
                        6'd5: opcode = OPC_BO_TO_B;
                        6'd6: opcode = OPC_AND_B_LSBCO;
                        6'd7: opcode = OPC_AO_TO_C;
                        6'd8: opcode = OPC_ADD_AC;
                        6'd9: opcode = OPC_CO_TO_C;
                        default: ;
                    endcase
                    last = (iteration == LAST_ITER) && (slot == 6'd9);
                end
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// ALU control sequencer: issues a fixed opcode sequence per op_sel,
// holding each opcode STEP_CYCLES cycles, then pulses done.
// Optional feature macro: ALU_SEQ_MUL_EN (multiply sequence; without it
// op_sel=11 completes immediately with err).
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 7,
    parameter int unsigned MUL_ITER    = 5
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic [1:0]  op_sel,
    input  logic        z_msb,
    output logic [11:0] opcode,
    output logic        opcode_valid,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [7:0] HOLD_LAST = 8'(STEP_CYCLES - 1);
    localparam logic [2:0] LAST_ITER = 3'(MUL_ITER - 1);

    state_e      state_q;
    op_e         op_q;
    op_e         op_in;
    op_e         rom_op;
    logic [5:0]  step_q;
    logic [5:0]  nxt_step;
    logic [2:0]  iter_q;
    logic [2:0]  nxt_iter;
    logic [7:0]  hold_q;
    logic        corr_q;
    logic        corr_nxt;
    logic        last_q;
    logic        step_end;
    logic [11:0] rom_opcode;
    logic        rom_last;

    assign op_in    = op_e'(op_sel);
    assign step_end = (hold_q == HOLD_LAST);

    // Next-step pointer fed to the ROM; the ROM output is registered on the
    // edge that starts that step, so z_msb is sampled in SHR_C's final cycle.
    always_comb begin
        rom_op   = op_q;
        nxt_step = step_q + 6'd1;
        nxt_iter = iter_q;
        corr_nxt = corr_q;
        if (state_q == ST_IDLE) begin
            rom_op   = op_in;
            nxt_step = '0;
            nxt_iter = '0;
            corr_nxt = 1'b0;
        end else if (op_q == OP_MUL) begin
            if ((step_q == MUL_SHR_C_POS) && (iter_q == LAST_ITER) && z_msb)
                corr_nxt = 1'b1;
            if ((step_q == MUL_WRAP_POS) && (iter_q != LAST_ITER)) begin
                nxt_step = MUL_BODY_START;
                nxt_iter = iter_q + 3'd1;
            end
        end
    end

    alu_seq_rom #(
        .MUL_ITER (MUL_ITER)
    ) u_rom (
        .op        (rom_op),
        .step      (nxt_step),
        .iteration (nxt_iter),
        .corr      (corr_nxt),
        .opcode    (rom_opcode),
        .last      (rom_last)
    );

    // Sequencer FSM with registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_ADD;
            step_q       <= '0;
            iter_q       <= '0;
            hold_q       <= '0;
            corr_q       <= 1'b0;
            last_q       <= 1'b0;
            opcode       <= '0;
            opcode_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q <= op_in;
                        busy <= 1'b1;
                        if (!op_supported(op_in)) begin
                            state_q <= ST_DONE;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else begin
                            state_q      <= ST_ISSUE;
                            opcode       <= rom_opcode;
                            opcode_valid <= 1'b1;
                            last_q       <= rom_last;
                            step_q       <= nxt_step;
                            iter_q       <= nxt_iter;
                            corr_q       <= corr_nxt;
                            hold_q       <= '0;
                        end
                    end
                end
                ST_ISSUE, ST_HOLD: begin
                    if (step_end) begin
                        if (last_q) begin
                            state_q      <= ST_DONE;
                            opcode       <= '0;
                            opcode_valid <= 1'b0;
                            done         <= 1'b1;
                        end else begin
                            state_q <= ST_ISSUE;
                            opcode  <= rom_opcode;
                            last_q  <= rom_last;
                            step_q  <= nxt_step;
                            iter_q  <= nxt_iter;
                            corr_q  <= corr_nxt;
                            hold_q  <= '0;
                        end
                    end else begin
                        state_q <= ST_HOLD;
                        hold_q  <= hold_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    op_q    <= OP_ADD;
                    step_q  <= '0;
                    iter_q  <= '0;
                    hold_q  <= '0;
                    corr_q  <= 1'b0;
                    last_q  <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    err     <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer (STEP_CYCLES=7, MUL_ITER=5).
// Multiply cases run when ALU_SEQ_MUL_EN is defined; otherwise the
// unsupported-op path is exercised.
module tb_alu_sequencer;

    localparam int STEP = 7;
    localparam int MI   = 5;

    localparam logic [11:0] LOAD_XB     = 12'b000000001011;
    localparam logic [11:0] LOAD_YC     = 12'b000000001100;
    localparam logic [11:0] ADD_BC_AO   = 12'b001000000000;
    localparam logic [11:0] TWOS_B_AO   = 12'b001000001000;
    localparam logic [11:0] SHR_B_AO    = 12'b001000000100;
    localparam logic [11:0] AO_TO_B     = 12'b100000001011;
    localparam logic [11:0] AND_B_LSBC  = 12'b001000000101;
    localparam logic [11:0] SHL_B       = 12'b001000010011;
    localparam logic [11:0] SHR_C       = 12'b000000101010;
    localparam logic [11:0] BO_TO_B     = 12'b100001001011;
    localparam logic [11:0] TWOS_B_BO   = 12'b001000011000;
    localparam logic [11:0] AO_TO_A     = 12'b100000001001;
    localparam logic [11:0] AND_B_LSBCO = 12'b001110000101;
    localparam logic [11:0] AO_TO_C     = 12'b010000101100;
    localparam logic [11:0] ADD_AC      = 12'b000000000000;
    localparam logic [11:0] CO_TO_C     = 12'b010010001100;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op_sel = 2'b00;
    logic        z_msb = 1'b0;
    logic [11:0] opcode;
    logic        opcode_valid;
    logic        busy;
    logic        done;
    logic        err;

    alu_sequencer #(
        .STEP_CYCLES (STEP),
        .MUL_ITER    (MI)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .start        (start),
        .op_sel       (op_sel),
        .z_msb        (z_msb),
        .opcode       (opcode),
        .opcode_valid (opcode_valid),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          is_done;
        logic [11:0] opc;
        bit          err;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  n_tests = 0;
    int  n_fail  = 0;
    int  exp_cyc;
    int  c0;

    task automatic push_op(input logic [11:0] oc);
        ev_t e;
        for (int i = 0; i < STEP; i++) begin
            e.cyc = exp_cyc; e.is_done = 1'b0; e.opc = oc; e.err = 1'b0;
            exp_q.push_back(e);
            exp_cyc++;
        end
    endtask

    task automatic push_done(input bit er);
        ev_t e;
        e.cyc = exp_cyc; e.is_done = 1'b1; e.opc = '0; e.err = er;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic issue(input logic [1:0] op);
        @(negedge CLK);
        start = 1'b1;
        op_sel = op;
        c0 = cyc;
        exp_cyc = c0 + 1;
        @(posedge CLK);
        #1 start = 1'b0;
    endtask

    task automatic drain(input int budget, input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge CLK);
            k++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain actual_remaining=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge CLK);
        chk({name, "_idle_busy"}, busy, 0);
        chk({name, "_idle_done"}, done, 0);
    endtask

    task automatic exp_add();
        push_op(LOAD_XB); push_op(LOAD_YC); push_op(ADD_BC_AO); push_done(1'b0);
    endtask

    task automatic exp_shr();
        push_op(LOAD_XB); push_op(SHR_B_AO); push_op(AO_TO_B); push_op(SHR_B_AO); push_done(1'b0);
    endtask

    task automatic exp_mul(input bit corr);
        push_op(LOAD_XB); push_op(LOAD_YC); push_op(AND_B_LSBC);
        for (int i = 0; i < MI; i++) begin
            push_op(SHL_B); push_op(SHR_C);
            if (corr && i == MI - 1) begin
                push_op(BO_TO_B); push_op(TWOS_B_BO);
            end
            push_op(AO_TO_A); push_op(BO_TO_B); push_op(AND_B_LSBCO);
            push_op(AO_TO_C); push_op(ADD_AC); push_op(CO_TO_C);
        end
        push_done(1'b0);
    endtask

    // z_msb is flipped from its background level only in the final cycle of
    // the last SHR_C step (cycle c0+259 for 7-cycle steps, 5 iterations).
    task automatic run_mul(input bit zdef, input bit corr, input string name);
        z_msb = zdef;
        issue(2'b11);
        exp_mul(corr);
        for (int k = 0; k < 340 && exp_q.size() != 0; k++) begin
            @(negedge CLK);
            z_msb = (cyc == c0 + 259) ? ~zdef : zdef;
        end
        z_msb = 1'b0;
        drain(5, name);
    endtask

    // Monitor: every cycle the DUT presents an opcode or done, pop and compare
    always @(negedge CLK) begin
        if (RST_N && (opcode_valid || done)) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output cyc=%0d actual valid=%0b done=%0b err=%0b opcode=%b required no output",
                         cyc, opcode_valid, done, err, opcode);
            end else begin
                mon_e = exp_q.pop_front();
                if (cyc != mon_e.cyc || opcode_valid !== !mon_e.is_done || done !== mon_e.is_done ||
                    err !== mon_e.err || busy !== 1'b1 || opcode !== mon_e.opc) begin
                    n_fail++;
                    $display("FAIL seq_event actual cyc=%0d valid=%0b done=%0b err=%0b busy=%0b opcode=%b required cyc=%0d valid=%0b done=%0b err=%0b busy=1 opcode=%b",
                             cyc, opcode_valid, done, err, busy, opcode,
                             mon_e.cyc, !mon_e.is_done, mon_e.is_done, mon_e.err, mon_e.opc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rst_at;
        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_opcode", opcode, 0);
        chk("rst_valid", opcode_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        #2 RST_N = 1'b1;

        // Add; op_sel changed while busy must not matter
        issue(2'b00);
        exp_add();
        op_sel = 2'b11;
        drain(40, "add");

        // Two's complement
        issue(2'b01);
        push_op(LOAD_XB); push_op(TWOS_B_AO); push_done(1'b0);
        drain(40, "twos");

        // Shift right by 2, with a start pulse at cycle 10 that must be ignored
        issue(2'b10);
        exp_shr();
        op_sel = 2'b00;
        while (cyc < c0 + 10) @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        drain(60, "shr");

        // Back-to-back: add, then twos started in the IDLE cycle right after done
        issue(2'b00);
        exp_add();
        while (cyc < c0 + 22) @(negedge CLK);
        issue(2'b01);
        push_op(LOAD_XB); push_op(TWOS_B_AO); push_done(1'b0);
        drain(80, "b2b");

`ifdef ALU_SEQ_MUL_EN
        run_mul(1'b1, 1'b0, "mul_nocorr");
        run_mul(1'b0, 1'b1, "mul_corr");
        z_msb = 1'b0;
        issue(2'b11);
        exp_mul(1'b0);
        rst_at = 50;
`else
        // Unsupported multiply: straight to done with err, no opcodes
        issue(2'b11);
        push_done(1'b1);
        drain(10, "mul_unsup");
        issue(2'b10);
        exp_shr();
        rst_at = 15;
`endif
        // Asynchronous reset mid-sequence
        while (cyc < c0 + rst_at) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("midrst_opcode", opcode, 0);
        chk("midrst_valid", opcode_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err", err, 0);
        exp_q.delete();
        @(negedge CLK);
        chk("inrst_busy", busy, 0);
        #2 RST_N = 1'b1;
        @(negedge CLK);
        chk("postrst_done", done, 0);
        chk("postrst_valid", opcode_valid, 0);
        @(negedge CLK);
        chk("postrst_done2", done, 0);

        issue(2'b00);
        exp_add();
        drain(40, "add_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter STEP_CYCLES, 7, cycles each opcode is held (legal 1..255).
REQ-002 SHALL have parameter MUL_ITER, 5, multiply loop iterations (legal 1..7).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-006 SHALL have port op_sel  input  2  00 add, 01 two's complement X, 10 X>>2, 11 multiply.
REQ-007 SHALL have port z_msb  input  1  datapath Z[15], used for multiply sign correction.
REQ-008 SHALL have port opcode  output  12  opcode driven to the ALU control unit.
REQ-009 SHALL have port opcode_valid  output  1  opcode is a live step.
REQ-010 SHALL have ports busy, done, err  output  1 each  in operation / 1-cycle completion pulse / completion with unsupported op.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, HOLD, DONE; IDLE->ISSUE on start; ISSUE->HOLD; HOLD->ISSUE (more steps) or DONE (last step expires); DONE->IDLE.
REQ-012 SHALL latch op_sel on start acceptance; op_sel changes while busy SHALL be ignored.
REQ-013 SHALL drive the first opcode with opcode_valid=1 on the cycle after acceptance and hold each opcode exactly STEP_CYCLES cycles, no gap between steps.
REQ-014 SHALL issue sequences: add = LOAD_XB, LOAD_YC, ADD_BC_AO; twos = LOAD_XB, TWOS_B_AO; shr2 = LOAD_XB, SHR_B_AO, AO_TO_B, SHR_B_AO.
REQ-015 SHALL issue multiply = LOAD_XB, LOAD_YC, AND_B_LSBC, then MUL_ITER x {SHL_B, SHR_C, [corr], AO_TO_A, BO_TO_B, AND_B_LSBCO, AO_TO_C, ADD_AC, CO_TO_C}.
REQ-016 SHALL insert [corr] = BO_TO_B, TWOS_B_BO only in the last iteration and only if z_msb=1 on the final cycle of that iteration's SHR_C step.
REQ-017 SHALL use opcode values: LOAD_XB 000000001011, LOAD_YC 000000001100, ADD_BC_AO 001000000000, TWOS_B_AO 001000001000, SHR_B_AO 001000000100, AO_TO_B 100000001011, AND_B_LSBC 001000000101, SHL_B 001000010011, SHR_C 000000101010, BO_TO_B 100001001011, TWOS_B_BO 001000011000, AO_TO_A 100000001001, AND_B_LSBCO 001110000101, AO_TO_C 010000101100, ADD_AC 000000000000, CO_TO_C 010010001100.
REQ-018 SHALL drive opcode=0 and opcode_valid=0 in IDLE and DONE.
REQ-019 SHALL assert busy from the cycle after acceptance through the DONE cycle inclusive; start while busy SHALL be ignored, not queued.
REQ-020 SHALL pulse done for exactly the one DONE cycle; err=1 only in that cycle when the op was unsupported.
REQ-021 SHALL keep the step counter 6-bit and the hold counter 8-bit; total steps never exceed 3+8*MUL_ITER+2.
REQ-022 SHALL accept a new start in the IDLE cycle immediately following DONE.

Reset
REQ-023 SHALL, on RST_N low (any time, including mid-sequence), force IDLE, clear counters, latched op and correction flag, and drive opcode=0, opcode_valid=0, busy=0, done=0, err=0 immediately.
REQ-024 SHALL resume normal operation on the first CLK edge after RST_N deasserts, with no phantom done.

Configuration
REQ-025 SHALL compile the multiply sequence only when ALU_SEQ_MUL_EN is defined; without it op_sel=11 SHALL go IDLE->DONE with done=1, err=1 on the cycle after acceptance, issuing no opcodes.

Structure
REQ-026 SHALL place opcode constants, op_sel encodings and the FSM state type in shared package alu_seq_pkg.
REQ-027 SHALL implement step-to-opcode lookup in sub-module alu_seq_rom (inputs: op, step, iteration, corr flag; outputs: opcode, last).

Verification (STEP_CYCLES=7, MUL_ITER=5; start accepted at cycle 0)
REQ-028 Add: opcodes LOAD_XB cycles 1-7, LOAD_YC 8-14, ADD_BC_AO 15-21; done=1 cycle 22 only; busy 1-22.
REQ-029 Shift: op_sel=10 -> four steps as REQ-014, done cycle 29; start pulsed at cycle 10 ignored.
REQ-030 Multiply, z_msb=0: 43 steps, done cycle 302; no TWOS_B_BO issued.
REQ-031 Multiply, z_msb=1 during last SHR_C: 45 steps, BO_TO_B then TWOS_B_BO after last SHR_C, done cycle 316.
REQ-032 RST_N low at cycle 50 of multiply: all outputs 0 same cycle; new add after release completes per REQ-028 timing.
REQ-033 Macro undefined, op_sel=11: done=1, err=1 at cycle 1, opcode_valid never 1.
